icb_apb_router: RTL and testbench

- Parametrised successor to the fixed one-ICB-to-four-APB bridge top.
- Accepts ICB command/response transactions on one slave port and routes each to one of NUM_APB APB4 master channels by address decode.
- Buffers up to CMD_DEPTH commands in order and executes them one at a time on the selected APB channel.
- Returns read data and an error flag on the ICB response channel, strictly in order.

---
 rtl/icb_apb_router.sv | 125 ++++++++++++
 tb/tb_icb_apb_router.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icb_apb_router.sv
// icb_apb_router: ICB slave routed by address decode to NUM_APB APB4 masters through an in-order command FIFO.
// Optional APB_TIMEOUT_EN macro adds an ACCESS-phase watchdog that aborts after TIMEOUT wait cycles.
module icb_apb_router #(
  parameter int NUM_APB = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CMD_DEPTH = 4,
  parameter int SEL_LSB = 12,
  parameter logic [AW-1:0] ADDR_BASE = AW'(32'h2000_0000),
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icb_cmd_valid,
  output logic                  icb_cmd_ready,
  input  logic [AW-1:0]         icb_cmd_addr,
  input  logic                  icb_cmd_read,
  input  logic [DW-1:0]         icb_cmd_wdata,
  input  logic [DW/8-1:0]       icb_cmd_wmask,
  output logic                  icb_rsp_valid,
  input  logic                  icb_rsp_ready,
  output logic [DW-1:0]         icb_rsp_rdata,
  output logic                  icb_rsp_err,
  output logic [NUM_APB-1:0]    apb_psel,
  output logic [NUM_APB-1:0]    apb_penable,
  output logic [AW-1:0]         apb_paddr,
  output logic                  apb_pwrite,
  output logic [DW-1:0]         apb_pwdata,
  output logic [DW/8-1:0]       apb_pstrb,
  input  logic [NUM_APB-1:0]    apb_pready,
  input  logic [NUM_APB*DW-1:0] apb_prdata,
  input  logic [NUM_APB-1:0]    apb_pslverr
);
  localparam int CW = NUM_APB > 1 ? $clog2(NUM_APB) : 1;
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int EW = AW + 1 + DW + DW / 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [EW-1:0] mem [CMD_DEPTH];
  logic [PW:0] wp, rp;
  logic full, empty, push, pop, hit, rdy, tmo;
  logic [AW-1:0] h_addr;
  logic h_read;
  logic [DW-1:0] h_wdata;
  logic [DW/8-1:0] h_wmask;
  logic [CW-1:0] h_ch, ch;

  assign full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign empty = wp == rp;
  assign icb_cmd_ready = !full;
  assign push = icb_cmd_valid && !full;
  assign pop = state == IDLE && !empty;
  assign {h_addr, h_read, h_wdata, h_wmask} = mem[rp[PW-1:0]];
  assign h_ch = h_addr[SEL_LSB +: CW];
  assign hit = h_addr[AW-1:SEL_LSB+CW] == ADDR_BASE[AW-1:SEL_LSB+CW] && {1'b0, h_ch} < (CW+1)'(NUM_APB);
  assign rdy = apb_pready[ch];
  assign icb_rsp_valid = state == RESP;
  assign apb_psel = (state == SETUP || state == ACCESS) ? NUM_APB'(1) << ch : '0;
  assign apb_penable = state == ACCESS ? apb_psel : '0;

  always_ff @(posedge clk)
    if (push) mem[wp[PW-1:0]] <= {icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  // a pready in the same cycle the limit is reached still completes normally
  assign tmo = !rdy && tcnt == TW'(TIMEOUT);
  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt <= '0;
    else if (state == SETUP) tcnt <= '0;
    else if (state == ACCESS && !rdy) tcnt <= tcnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = empty ? IDLE : hit ? SETUP : RESP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  state_nx = (rdy || tmo) ? RESP : ACCESS;
      RESP:    state_nx = icb_rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      apb_paddr <= '0;
      apb_pwrite <= 1'b0;
      apb_pwdata <= '0;
      apb_pstrb <= '0;
      icb_rsp_rdata <= '0;
      icb_rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop && hit) begin
        ch <= h_ch;
        apb_paddr <= h_addr;
        apb_pwrite <= !h_read;
        apb_pwdata <= h_wdata;
        apb_pstrb <= h_read ? '0 : h_wmask;
      end
      if (pop && !hit) begin
        icb_rsp_rdata <= '0;
        icb_rsp_err <= 1'b1;
      end
      if (state == ACCESS && (rdy || tmo)) begin
        icb_rsp_rdata <= (rdy && !apb_pwrite) ? apb_prdata[int'(ch)*DW +: DW] : '0;
        icb_rsp_err <= rdy ? apb_pslverr[ch] : 1'b1;
      end
    end
endmodule

// File: tb/tb_icb_apb_router.sv
// tb_icb_apb_router: random + directed stimulus, register-per-channel reference model, decoupled scoreboard monitors.
module tb_icb_apb_router;
  logic clk = 0, rst = 1;
  logic icb_cmd_valid = 0, icb_cmd_ready, icb_cmd_read = 0;
  logic [31:0] icb_cmd_addr = 0, icb_cmd_wdata = 0;
  logic [3:0] icb_cmd_wmask = 0;
  logic icb_rsp_valid, icb_rsp_ready = 0, icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic [3:0] apb_psel, apb_penable, apb_pready = 0, apb_pslverr = 0, apb_pstrb;
  logic [31:0] apb_paddr, apb_pwdata;
  logic apb_pwrite;
  logic [127:0] apb_prdata = 0;

  icb_apb_router dut (
    .clk(clk), .rst(rst),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err(icb_rsp_err), .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_paddr(apb_paddr),
    .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb), .apb_pready(apb_pready),
    .apb_prdata(apb_prdata), .apb_pslverr(apb_pslverr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { int ch; logic [31:0] addr; logic wr; logic [31:0] wd; logic [3:0] strb; } apb_t;
  rsp_t rsp_q[$];
  apb_t apb_q[$];
  logic [31:0] ref_mem [4];
  logic [31:0] slv_mem [4];
  int total = 0, bad = 0;
  int wait_mode = -1;
  int rr_mode = 0;

  function automatic void check(string n, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, got, want);
    end
  endfunction

  // Reference: region hit on addr[31:14], channel addr[13:12], one register per channel,
  // slave flags an error whenever addr[7:4] == 0xF.
  task automatic model(input logic [31:0] a, input logic r, input logic [31:0] wd, input logic [3:0] wm);
    rsp_t e;
    apb_t p;
    int c;
    c = int'((a >> 12) % 4);
    if ((a >> 14) != (32'h2000_0000 >> 14)) begin
      e.rdata = 0;
      e.err = 1;
    end else begin
      e.err = ((a >> 4) % 16) == 15;
      e.rdata = r ? ref_mem[c] : 0;
      if (!r)
        for (int b = 0; b < 4; b++) if (wm[b]) ref_mem[c][8*b +: 8] = wd[8*b +: 8];
      p.ch = c; p.addr = a; p.wr = !r; p.wd = wd; p.strb = r ? 4'h0 : wm;
      apb_q.push_back(p);
    end
    rsp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic r, input logic [31:0] wd, input logic [3:0] wm,
                      input int lim, output bit acc);
    int n;
    n = 0;
    icb_cmd_valid = 1; icb_cmd_addr = a; icb_cmd_read = r; icb_cmd_wdata = wd; icb_cmd_wmask = wm;
    do begin
      @(negedge clk);
      acc = icb_cmd_ready;
      step();
      n++;
    end while (!acc && n < lim);
    if (acc) model(a, r, wd, wm);
    icb_cmd_valid = 0;
  endtask

  task automatic send_ok(input logic [31:0] a, input logic r, input logic [31:0] wd, input logic [3:0] wm);
    bit acc;
    send(a, r, wd, wm, 500, acc);
    check("cmd_accept", acc, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    check("drain_rsp", rsp_q.size(), 0);
    check("drain_apb", apb_q.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    icb_rsp_ready = rr_mode == 2 ? 1'($urandom % 2) : rr_mode == 1;
  end

  // APB slaves: noise on unselected channels, programmable wait states on the selected one.
  int wl = 0;
  always @(posedge clk) begin
    int c;
    #1;
    apb_pready = 4'($urandom);
    apb_pslverr = 4'($urandom);
    apb_prdata = {$urandom, $urandom, $urandom, $urandom};
    c = -1;
    for (int i = 0; i < 4; i++) if (apb_psel[i]) c = i;
    if (c >= 0) begin
      if (!apb_penable[c]) wl = wait_mode < 0 ? int'($urandom_range(0, 3)) : wait_mode;
      else begin
        apb_pready[c] = wl == 0;
        apb_prdata[c*32 +: 32] = slv_mem[c];
        apb_pslverr[c] = wl == 0 && apb_paddr[7:4] == 4'hF;
        if (wl == 0 && apb_pwrite)
          for (int b = 0; b < 4; b++) if (apb_pstrb[b]) slv_mem[c][8*b +: 8] = apb_pwdata[8*b +: 8];
        if (wl > 0) wl--;
      end
    end
  end

  apb_t cur;
  always @(negedge clk) begin
    if (!rst) begin
      check("psel_onehot0", $onehot0(apb_psel), 1);
      if (apb_psel != 0 && apb_penable == 0) begin
        check("apb_pending", apb_q.size() > 0, 1);
        if (apb_q.size() > 0) begin
          cur = apb_q.pop_front();
          check("apb_psel", apb_psel, 4'b1 << cur.ch);
          check("apb_paddr", apb_paddr, cur.addr);
          check("apb_pwrite", apb_pwrite, cur.wr);
          check("apb_pstrb", apb_pstrb, cur.strb);
          if (cur.wr) check("apb_pwdata", apb_pwdata, cur.wd);
        end
      end else if (apb_penable != 0) begin
        check("apb_penable", apb_penable, apb_psel);
        check("apb_paddr_hold", apb_paddr, cur.addr);
        check("apb_pstrb_hold", apb_pstrb, cur.strb);
      end
    end
  end

  logic held = 0;
  logic [32:0] held_v;
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && icb_rsp_valid) begin
      if (held) check("rsp_hold", {icb_rsp_err, icb_rsp_rdata}, held_v);
      if (icb_rsp_ready) begin
        check("rsp_pending", rsp_q.size() > 0, 1);
        if (rsp_q.size() > 0) begin
          e = rsp_q.pop_front();
          check("rsp_rdata", icb_rsp_rdata, e.rdata);
          check("rsp_err", icb_rsp_err, e.err);
        end
      end
      held = !icb_rsp_ready;
      held_v = {icb_rsp_err, icb_rsp_rdata};
    end else held = 0;
  end

  initial begin
    bit acc;
    int n;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      ref_mem[i] = 32'h1111_1111 * i;
      slv_mem[i] = ref_mem[i];
    end
    ref_mem[3] = 32'h1234_5678;
    slv_mem[3] = 32'h1234_5678;
    @(negedge clk);
    check("rst_psel", apb_psel, 0);
    check("rst_penable", apb_penable, 0);
    check("rst_paddr", apb_paddr, 0);
    check("rst_pwrite", apb_pwrite, 0);
    check("rst_pwdata", apb_pwdata, 0);
    check("rst_pstrb", apb_pstrb, 0);
    check("rst_rsp", {icb_rsp_valid, icb_rsp_err, icb_rsp_rdata}, 0);
    check("rst_cmd_ready", icb_cmd_ready, 1);
    step();
    rst = 0;
    rr_mode = 1;
    wait_mode = 0;
    step();
    send_ok(32'h2000_1004, 0, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk) check("lat_t1_psel", apb_psel, 0);
    @(negedge clk) check("lat_t2_psel", {apb_psel, apb_penable}, 8'h20);
    @(negedge clk) check("lat_t3_pen", {apb_psel, apb_penable, apb_pstrb}, 12'h22F);
    @(negedge clk) check("lat_t4_rsp", {icb_rsp_valid, apb_psel}, 5'h10);
    drain();
    wait_mode = 3;
    send_ok(32'h2000_3008, 1, 0, 0);
    drain();
    send_ok(32'h3000_0000, 1, 0, 0);
    drain();
    wait_mode = 0;
    send_ok(32'h2000_20F0, 0, 32'hCAFE_0001, 4'h3);
    drain();
    rr_mode = 0;
    for (int i = 0; i < 5; i++) send_ok(32'h2000_0000 + 32'h1000 * (i % 4) + 4 * i, 0, 32'hA000_0000 + i, 4'hF);
    send(32'h2000_1014, 0, 32'hA000_0005, 4'hF, 10, acc);
    check("full_stall", acc, 0);
    check("full_cmd_ready", icb_cmd_ready, 0);
    rr_mode = 1;
    send_ok(32'h2000_1014, 0, 32'hA000_0005, 4'hF);
    drain();
    wait_mode = 10000;
    send_ok(32'h2000_2010, 0, 32'h5555_AAAA, 4'hF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (apb_penable == 0 && n < 50);
    check("reach_access", apb_penable, 4'b0100);
    #2 rst = 1;
    #1 check("rst_async", {apb_psel, apb_penable, icb_rsp_valid}, 0);
    rsp_q.delete();
    apb_q.delete();
    for (int i = 0; i < 4; i++) ref_mem[i] = slv_mem[i];
    step();
    step();
    rst = 0;
    wait_mode = -1;
    @(negedge clk) check("rst_cmd_ready2", icb_cmd_ready, 1);
    step();
    rr_mode = 2;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) step();
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom;
        if ((a >> 14) == (32'h2000_0000 >> 14)) a = a ^ 32'h8000_0000;
      end else a = 32'h2000_0000 | ($urandom & 32'h3FFF);
      send_ok(a, 1'($urandom % 2), $urandom, 4'($urandom));
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
